// File: rtl/iir_out_buffer_pkg.sv
// iir_out_buffer_pkg: shared sample width and default FIFO geometry for the iir output stage
package iir_out_buffer_pkg;
  localparam int IOB_NB = 12;
  localparam int IOB_DEPTH = 8;
  localparam int IOB_AW = 3;
  localparam int IOB_DCW = 8;
endpackage

// File: rtl/iir_fifo_mem.sv
// iir_fifo_mem: DEPTH x NB register file, one synchronous write port, one asynchronous read port
module iir_fifo_mem
  import iir_out_buffer_pkg::*;
#(
  parameter int NB = IOB_NB,
  parameter int DEPTH = IOB_DEPTH,
  parameter int AW = IOB_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [NB-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [NB-1:0] rdata
);
  logic [NB-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/iir_out_buffer.sv
// iir_out_buffer: show-ahead elastic FIFO behind iir_filter with valid/ready output and drop accounting
module iir_out_buffer
  import iir_out_buffer_pkg::*;
#(
  parameter int NB = IOB_NB,
  parameter int DEPTH = IOB_DEPTH,
  parameter int AW = IOB_AW,
  parameter int DCW = IOB_DCW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vIn,
  input  logic [NB-1:0]  dIn,
  input  logic           rdy,
  output logic           vOut,
  output logic [NB-1:0]  dOut,
  output logic [AW:0]    count,
  output logic           full,
  output logic           empty,
  output logic           ovf,
  output logic [DCW-1:0] drops,
  input  logic           clr_ovf
);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] count_q, count_d;
  logic ovf_q, ovf_d;
  logic [DCW-1:0] drops_q, drops_d;
  logic push, pop, drop;
  logic [NB-1:0] rdata;
  iir_fifo_mem #(.NB(NB), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk), .we(push), .waddr(wr_q), .wdata(dIn), .raddr(rd_q), .rdata(rdata)
  );
  assign empty = count_q == '0;
  assign full  = count_q == CNT_FULL;
  assign vOut  = !empty;
  // memory is not reset, so mask the head while nothing valid is buffered
  assign dOut  = empty ? '0 : rdata;
  assign count = count_q;
  assign ovf   = ovf_q;
  assign drops = drops_q;
  always_comb begin
    pop = vOut & rdy;
    push = vIn & (!full | pop);
    drop = vIn & full & !pop;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    wr_d = push ? wr_q + 1'b1 : wr_q;
    count_d = (push & !pop) ? count_q + 1'b1 : (pop & !push) ? count_q - 1'b1 : count_q;
    ovf_d = drop | (ovf_q & !clr_ovf);
    // a drop coinciding with a clear restarts the tally at one
    drops_d = drop ? (clr_ovf ? DCW'(1) : (&drops_q ? drops_q : drops_q + 1'b1))
                   : (clr_ovf ? '0 : drops_q);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      drops_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      drops_q <= drops_d;
    end
endmodule

// File: tb/tb_iir_out_buffer.sv
// tb_iir_out_buffer: directed vector table plus hand sequences for wrap, saturation and async reset
module tb_iir_out_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vIn = 1'b0, rdy = 1'b0, clr_ovf = 1'b0;
  logic [11:0] dIn = '0;
  logic vOut, full, empty, ovf;
  logic [11:0] dOut;
  logic [3:0] count;
  logic [7:0] drops;
  int checks = 0, failures = 0;

  iir_out_buffer dut (
    .clk(clk), .rst(rst), .vIn(vIn), .dIn(dIn), .rdy(rdy),
    .vOut(vOut), .dOut(dOut), .count(count), .full(full), .empty(empty),
    .ovf(ovf), .drops(drops), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [11:0] d; logic r; logic c;
    logic ev; logic [11:0] ed; logic [3:0] ec; logic ef; logic ee; logic eo; logic [7:0] edr;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [11:0] d, logic r, logic c,
                              logic [11:0] ed, logic [3:0] ec, logic eo, logic [7:0] edr);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.c = c;
    t.ev = ec != 0; t.ed = ed; t.ec = ec; t.ef = ec == 8; t.ee = ec == 0;
    t.eo = eo; t.edr = edr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [27:0] exp);
    logic [27:0] act;
    act = {vOut, dOut, count, full, empty, ovf, drops};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got v=%b d=%h cnt=%0d f=%b e=%b ovf=%b drops=%0d, want v=%b d=%h cnt=%0d f=%b e=%b ovf=%b drops=%0d",
               name, act[27], act[26:15], act[14:11], act[10], act[9], act[8], act[7:0],
               exp[27], exp[26:15], exp[14:11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  function automatic logic [27:0] st(logic [11:0] d, logic [3:0] c, logic o, logic [7:0] dr);
    return {c != 0, d, c, c == 8, c == 0, o, dr};
  endfunction

  task automatic step(input logic v, input logic [11:0] d, input logic r, input logic c);
    vIn = v; dIn = d; rdy = r; clr_ovf = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // while in reset
    #2 chk("reset_hold", st(12'h0, 0, 0, 0));
    @(posedge clk); #1 rst = 1'b0;
    chk("after_release", st(12'h0, 0, 0, 0));
    // single sample through with rdy=1
    tbl.push_back(mk(1, 12'h7FF, 1, 0, 12'h7FF, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 1, 0, 12'h000, 0, 0, 0));
    // fill 1..8 with rdy=0
    for (int k = 1; k <= 8; k++) tbl.push_back(mk(1, 12'(k), 0, 0, 12'h001, 4'(k), 0, 0));
    // three drops while full
    for (int j = 1; j <= 3; j++) tbl.push_back(mk(1, 12'h0AA + 12'(j), 0, 0, 12'h001, 8, 1, 8'(j)));
    tbl.push_back(mk(0, 12'h000, 0, 1, 12'h001, 8, 0, 0));
    // drain: contents must still be 1..8
    for (int k = 1; k <= 7; k++) tbl.push_back(mk(0, 12'h000, 1, 0, 12'(k + 1), 4'(8 - k), 0, 0));
    tbl.push_back(mk(0, 12'h000, 1, 0, 12'h000, 0, 0, 0));
    // refill 0x10..0x17
    for (int k = 0; k < 8; k++) tbl.push_back(mk(1, 12'h010 + 12'(k), 0, 0, 12'h010, 4'(k + 1), 0, 0));
    // two drops, then drop with clear: drop wins and restarts at 1
    tbl.push_back(mk(1, 12'h3FF, 0, 0, 12'h010, 8, 1, 1));
    tbl.push_back(mk(1, 12'h3FF, 0, 0, 12'h010, 8, 1, 2));
    tbl.push_back(mk(1, 12'h3FF, 0, 1, 12'h010, 8, 1, 1));
    // full with simultaneous pop and push: no drop
    tbl.push_back(mk(1, 12'h800, 1, 0, 12'h011, 8, 1, 1));
    for (int k = 1; k <= 6; k++) tbl.push_back(mk(0, 12'h000, 1, 0, 12'h011 + 12'(k), 4'(8 - k), 1, 1));
    tbl.push_back(mk(0, 12'h000, 1, 0, 12'h800, 1, 1, 1));
    tbl.push_back(mk(0, 12'h000, 1, 0, 12'h000, 0, 1, 1));
    // rdy while empty has no effect; clear flags
    tbl.push_back(mk(0, 12'h000, 1, 1, 12'h000, 0, 0, 0));
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c);
      chk($sformatf("vec%0d", i), {tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].ef, tbl[i].ee, tbl[i].eo, tbl[i].edr});
    end
    // streaming with wrap: output is input delayed one cycle, count steady at 1
    for (int i = 0; i < 20; i++) begin
      step(1, 12'h500 + 12'(i), 1, 0);
      chk($sformatf("stream%0d", i), st(12'h500 + 12'(i), 1, 0, 0));
    end
    step(0, 12'h000, 1, 0);
    chk("stream_drain", st(12'h000, 0, 0, 0));
    // drop counter saturation
    for (int k = 0; k < 8; k++) step(1, 12'h600 + 12'(k), 0, 0);
    chk("sat_fill", st(12'h600, 8, 0, 0));
    for (int k = 0; k < 260; k++) step(1, 12'hFFF, 0, 0);
    chk("sat_drops", st(12'h600, 8, 1, 8'hFF));
    for (int k = 0; k < 3; k++) step(0, 12'h000, 1, 0);
    chk("pop_to_5", st(12'h603, 5, 1, 8'hFF));
    // asynchronous reset mid-clock with count=5
    vIn = 1'b0; rdy = 1'b0;
    #2 rst = 1'b1;
    #1 chk("async_rst", st(12'h000, 0, 0, 0));
    @(posedge clk); #1 chk("rst_held", st(12'h000, 0, 0, 0));
    rst = 1'b0;
    step(1, 12'h123, 0, 0);
    chk("post_rst_sample", st(12'h123, 1, 0, 0));
    step(0, 12'h000, 1, 0);
    chk("post_rst_empty", st(12'h000, 0, 0, 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
